// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// The rxd pin is resynchronised, a start edge arms a cycle counter, and each
// bit is sampled once near its centre. A good frame updates rxd_data with a
// one-cycle rxd_valid strobe; a zero stop bit raises a one-cycle frame_err
// strobe and parks the receiver until the line returns to idle.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_valid,
    output logic       frame_err,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for rxd_s low
    // START  | counting to mid start bit, then re-checking the line
    // DATA   | sampling the 8 data bits, LSB first, one per bit period
    // STOP   | sampling the stop bit, issuing rxd_valid or frame_err
    // BREAK  | stop bit was low; wait for the line to go high again

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Mid-bit offset of the start check, and the last count of a bit period.
    localparam logic [CW-1:0] LP_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_rxd_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_err;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_valid_nxt;
    logic          w_err_nxt;
    logic          w_cnt_last;
    logic          w_cnt_half;

    assign w_cnt_last = (r_cnt == LP_LAST);
    assign w_cnt_half = (r_cnt == LP_HALF);

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and datapath decode; strobes default low so each is a
    // single-cycle pulse registered at the stop-sample edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rxd_s) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (w_cnt_half) begin
                    w_cnt_nxt = '0;
                    if (r_rxd_s) begin
                        // Line went back high before mid start bit: glitch.
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_cnt_last) begin
                    // Shift right so the first (LSB) bit ends up in bit 0.
                    w_shift_nxt = {r_rxd_s, r_shift[7:1]};
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_rxd_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_BREAK: begin
                // No start detection here: a held-low line is a break,
                // not a stream of frames.
                w_cnt_nxt = '0;
                if (r_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign rxd_data  = r_data;
    assign rxd_valid = r_valid;
    assign frame_err = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed stimulus for uart_rx, checked against
// a frame-level reference model (expected byte, error flag and strobe cycle).
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = (N - 1) / 2;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rxd_data;
    logic       rxd_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rxd_data  (rxd_data),
        .rxd_valid (rxd_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data;
    int         cyc;
    int         n_vec;
    int         n_err;
    int         last_strobe;
    int         prev_strobe;
    logic       prev_busy;

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue;
    // an expectation whose cycle passes without a strobe is a miss.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rxd_valid || frame_err) begin
                chk("valid_err_excl", 32'(rxd_valid & frame_err), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_kind_err", 32'(frame_err), 32'(e.err));
                    chk("rxd_data", rxd_data, e.data);
                    chk("busy_at_strobe", 32'(busy), e.err ? 1 : 0);
                    chk("busy_before_strobe", 32'(prev_busy), 1);
                end
                prev_strobe = last_strobe;
                last_strobe = cyc;
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                e = exp_q.pop_front();
                chk("missed_strobe", cyc, e.cyc);
            end
        end
        prev_busy = busy;
    end

    // Drive one 10-bit frame starting at the current negedge and record what
    // the receiver must report: the strobe follows the stop sample, which is
    // 2 sync edges + 1 detect edge + 1 + H + 9 bit periods after the fall.
    task automatic send_frame(input logic [7:0] d, input bit stop);
        exp_t x;
        int   t0;
        t0     = cyc + 3;
        x.cyc  = t0 + 1 + H + 9 * N;
        x.err  = !stop;
        x.data = stop ? d : model_data;
        if (stop) model_data = d;
        exp_q.push_back(x);
        rxd = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (N) @(negedge clk);
        end
        rxd = stop;
        repeat (N) @(negedge clk);
    endtask

    // Wait (bounded) until every expected strobe has been seen.
    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 20 * N) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bcnt;
        n_vec       = 0;
        n_err       = 0;
        model_data  = 8'h00;
        last_strobe = 0;
        prev_strobe = 0;
        prev_busy   = 1'b0;
        rst_n       = 1'b0;
        rxd         = 1'b1;

        // Reset held with a toggling line: all outputs stay at zero.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rxd = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs", {rxd_data, rxd_valid, frame_err, busy}, 0);
        end
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_data", rxd_data, 0);

        // Single frame.
        send_frame(8'hA5, 1'b1);
        drain();
        chk("single_data", rxd_data, 8'hA5);
        repeat (N) @(negedge clk);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain();
        chk("b2b_spacing", last_strobe - prev_strobe, 10 * N);
        chk("b2b_data", rxd_data, 8'hFF);
        repeat (N) @(negedge clk);

        // Short glitch: false start, busy for H+1 cycles, no strobe.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd  = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("glitch_busy_cycles", bcnt, H + 1);
        chk("glitch_data", rxd_data, 8'hFF);

        // Framing error after a good byte; line held low as a break.
        send_frame(8'h5A, 1'b1);
        drain();
        send_frame(8'h3C, 1'b0);
        repeat (50) @(negedge clk);
        chk("break_busy", 32'(busy), 1);
        chk("break_data", rxd_data, 8'h5A);
        drain();
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_release_busy", 32'(busy), 0);
        send_frame(8'h81, 1'b1);
        drain();
        chk("after_break_data", rxd_data, 8'h81);
        repeat (N) @(negedge clk);

        // Reset in the middle of data bit 3 of 0xC3.
        rxd = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = (i == 2) ? 1'b0 : 1'b1;
            repeat (N) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", {rxd_data, rxd_valid, frame_err, busy}, 0);
        exp_q.delete();
        model_data = 8'h00;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_data", rxd_data, 0);
        send_frame(8'h7E, 1'b1);
        drain();
        chk("post_reset_frame", rxd_data, 8'h7E);

        // Randomized frames: random bytes, occasional bad stop, random gaps.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] d;
            bit         bad;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(d, !bad);
            if (bad) begin
                repeat ($urandom_range(1, 3 * N)) @(negedge clk);
                rxd = 1'b1;
                repeat ($urandom_range(4, 2 * N)) @(negedge clk);
            end else if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 2 * N)) @(negedge clk);
            end
        end
        drain();
        chk("random_final_data", rxd_data, model_data);
        repeat (N) @(negedge clk);
        chk("final_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
